// File: rtl/if_agc_pkg.sv
// Shared types and constants for the IF-stage automatic gain controller.
package if_agc_pkg;

  localparam int GAIN_W = 3;
  localparam logic [GAIN_W-1:0] GAIN_MAX = 3'd5;

  // Controller state: MANUAL passes the SPI gain through, MEASURE evaluates
  // each window, SETTLE counts one window without acting on it.
  typedef enum logic [1:0] {
    ST_MANUAL  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_SETTLE  = 2'd2
  } state_e;

  // Codes above GAIN_MAX are not legal filter settings; pin them to the top.
  function automatic logic [GAIN_W-1:0] clamp_gain(input logic [GAIN_W-1:0] code);
    return (code > GAIN_MAX) ? GAIN_MAX : code;
  endfunction

endpackage

// File: rtl/if_agc_peak.sv
// Window peak detector: saturating magnitude, sample-count window and running max.
// A sample is consumed on every cycle where sample_en is high and clear is low;
// win_done flags the cycle whose sample completes the window, and peak_final
// on that cycle is the window peak including that sample.
module if_agc_peak #(
  parameter int WIN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                sample_en,
  input  logic [7:0]          sample_in,
  output logic                win_done,
  output logic [6:0]          peak_final
);

  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [6:0]          peak_acc_q, peak_acc_d;
  logic [7:0]          neg_val;
  logic [6:0]          mag;

  // Magnitude with -128 saturated to 127, then window bookkeeping.
  always_comb begin
    neg_val    = ~sample_in + 8'd1;
    mag        = sample_in[7] ? (neg_val[7] ? 7'h7f : neg_val[6:0]) : sample_in[6:0];
    peak_final = (mag > peak_acc_q) ? mag : peak_acc_q;
    win_done   = !clear && sample_en && (win_cnt_q == '1);
    win_cnt_d  = win_cnt_q;
    peak_acc_d = peak_acc_q;
    if (clear) begin
      win_cnt_d  = '0;
      peak_acc_d = '0;
    end else if (sample_en) begin
      win_cnt_d  = win_cnt_q + 1'b1;
      peak_acc_d = win_done ? 7'd0 : peak_final;
    end
  end

  // Window counter and peak accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q  <= '0;
      peak_acc_q <= '0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      peak_acc_q <= peak_acc_d;
    end
  end

endmodule

// File: rtl/if_agc_ctrl.sv
// Automatic gain controller for the 455 kHz IF filter: steps the 3-bit output
// scaling select down on loud windows and up after a run of quiet windows.
// state_dbg exposes the controller state for observation only.
module if_agc_ctrl
  import if_agc_pkg::*;
#(
  parameter int WIN_LOG2     = 8,
  parameter int HI_THRESH    = 96,
  parameter int LO_THRESH    = 24,
  parameter int HOLD_WINDOWS = 4,
  parameter int LOCK_WINDOWS = 2,
  parameter int GAIN_INIT    = 0
) (
  input  logic              clk,
  input  logic              RSTb,
  input  logic              sample_en,
  input  logic [7:0]        if_filt_in,
  input  logic              agc_en,
  input  logic [GAIN_W-1:0] gain_manual,
  output logic [GAIN_W-1:0] gain_out,
  output logic              gain_step,
  output logic              agc_locked,
  output logic [6:0]        peak_out,
  output state_e            state_dbg
);

  localparam int QW = $clog2(HOLD_WINDOWS + 1);
  localparam int LW = $clog2(LOCK_WINDOWS + 1);
  localparam logic [QW-1:0] HOLD_N = QW'(HOLD_WINDOWS);
  localparam logic [LW-1:0] LOCK_N = LW'(LOCK_WINDOWS);

  state_e            state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic              step_q, step_d;
  logic              locked_q, locked_d;
  logic [6:0]        peak_q, peak_d;
  logic [QW-1:0]     quiet_q, quiet_d, quiet_inc;
  logic [LW-1:0]     lock_q, lock_d, lock_inc;

  logic              peak_clear;
  logic              win_done;
  logic [6:0]        peak_final;

  // Partial windows are discarded whenever AGC is off or just being enabled.
  assign peak_clear = (state_q == ST_MANUAL) || !agc_en;

  if_agc_peak #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_peak (
    .clk        (clk),
    .rst_n      (RSTb),
    .clear      (peak_clear),
    .sample_en  (sample_en),
    .sample_in  (if_filt_in),
    .win_done   (win_done),
    .peak_final (peak_final)
  );

  // Next-state, gain decision and hold/lock counters.
  always_comb begin
    state_d   = state_q;
    gain_d    = gain_q;
    step_d    = 1'b0;
    locked_d  = locked_q;
    peak_d    = peak_q;
    quiet_d   = quiet_q;
    lock_d    = lock_q;
    quiet_inc = (quiet_q >= HOLD_N) ? HOLD_N : quiet_q + 1'b1;
    lock_inc  = (lock_q >= LOCK_N) ? LOCK_N : lock_q + 1'b1;
    if (!agc_en) begin
      state_d  = ST_MANUAL;
      gain_d   = clamp_gain(gain_manual);
      locked_d = 1'b0;
      quiet_d  = '0;
      lock_d   = '0;
    end else begin
      case (state_q)
        ST_MANUAL: begin
          // AGC picks up from whatever gain is currently applied.
          state_d = ST_MEASURE;
        end
        ST_MEASURE: begin
          if (win_done) begin
            peak_d = peak_final;
            if (peak_final >= 7'(HI_THRESH)) begin
              quiet_d  = '0;
              lock_d   = '0;
              locked_d = 1'b0;
              if (gain_q != '0) begin
                gain_d  = gain_q - 1'b1;
                step_d  = 1'b1;
                state_d = ST_SETTLE;
              end
            end else if (peak_final < 7'(LO_THRESH)) begin
              lock_d   = '0;
              locked_d = 1'b0;
              quiet_d  = quiet_inc;
              if (quiet_inc >= HOLD_N && gain_q < GAIN_MAX) begin
                gain_d  = gain_q + 1'b1;
                step_d  = 1'b1;
                quiet_d = '0;
                state_d = ST_SETTLE;
              end
            end else begin
              quiet_d  = '0;
              lock_d   = lock_inc;
              locked_d = (lock_inc >= LOCK_N);
            end
          end
        end
        ST_SETTLE: begin
          // Let the filter transient decay: report the peak, do not act on it.
          if (win_done) begin
            peak_d  = peak_final;
            state_d = ST_MEASURE;
          end
        end
        default: state_d = ST_MANUAL;
      endcase
    end
  end

  // Controller registers.
  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      state_q  <= ST_MANUAL;
      gain_q   <= GAIN_W'(GAIN_INIT);
      step_q   <= 1'b0;
      locked_q <= 1'b0;
      peak_q   <= '0;
      quiet_q  <= '0;
      lock_q   <= '0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      step_q   <= step_d;
      locked_q <= locked_d;
      peak_q   <= peak_d;
      quiet_q  <= quiet_d;
      lock_q   <= lock_d;
    end
  end

  assign gain_out   = gain_q;
  assign gain_step  = step_q;
  assign agc_locked = locked_q;
  assign peak_out   = peak_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/if_agc_ctrl.md
Name: if_agc_ctrl

Overview:
Automatic gain controller for the 455kHz IF filter stage. It watches the 8-bit filter output, measures peak magnitude over fixed windows, and drives the filter's 3-bit output-scaling select (gain code). It sits between the SPI register file and the IF filter. When AGC is disabled, the SPI manual gain passes straight through.

Parameters:
WIN_LOG2, 8, log2 of samples per measurement window (256 samples).
HI_THRESH, 96, peak magnitude at or above which gain is stepped down.
LO_THRESH, 24, peak magnitude below which a window counts as "quiet".
HOLD_WINDOWS, 4, consecutive quiet windows required before gain is stepped up.
LOCK_WINDOWS, 2, consecutive in-band windows required to assert agc_locked.
GAIN_INIT, 0, gain code loaded at reset.

Ports:
clk  in  1  system clock
RSTb  in  1  asynchronous active-low reset
sample_en  in  1  qualifies if_filt_in; one sample is consumed per cycle where this is high
if_filt_in  in  8  signed IF filter output
agc_en  in  1  from SPI; 1 = automatic, 0 = manual
gain_manual  in  3  from SPI; manual gain code
gain_out  out  3  gain code to the IF filter; 0 = least gain, 5 = most gain
gain_step  out  1  one-cycle pulse when gain_out changes under AGC
agc_locked  out  1  level; peak has been in band for LOCK_WINDOWS windows
peak_out  out  7  peak magnitude of the last completed window

Behaviour:
- Reset (RSTb low, asynchronous):
  - gain_out=GAIN_INIT, gain_step=0, agc_locked=0, peak_out=0.
  - All counters cleared; state=MANUAL.
- Magnitude:
  - mag = |if_filt_in|, saturated to 7 bits; -128 gives 127.
- Gain clamp:
  - Legal codes are 0..5 (GAIN_MAX=5). Manual codes 6 and 7 map to 5.
- States: MANUAL, MEASURE, SETTLE.
  - MANUAL: gain_out <= clamp(gain_manual) every cycle; agc_locked=0; counters held at 0. agc_en=1 moves to MEASURE the next cycle, starting from the current gain_out.
  - MEASURE: on each sample_en, peak_acc <= max(peak_acc, mag) and win_cnt increments. The sample that wraps win_cnt (the 2^WIN_LOG2-th sample) is included in the peak. Window end then triggers evaluation, registered in the same edge:
    - Loud (peak >= HI_THRESH) and gain_out > 0: gain_out decrements, gain_step=1, quiet_cnt=0, lock_cnt=0, agc_locked=0, go to SETTLE.
    - Loud at gain 0: no change; quiet_cnt=0, lock_cnt=0, agc_locked=0.
    - Quiet (peak < LO_THRESH): quiet_cnt increments, lock_cnt=0, agc_locked=0. If quiet_cnt reaches HOLD_WINDOWS and gain_out < 5: gain_out increments, gain_step=1, quiet_cnt=0, go to SETTLE. At gain 5, quiet_cnt saturates at HOLD_WINDOWS and gain is unchanged.
    - In band: quiet_cnt=0; lock_cnt increments, saturating at LOCK_WINDOWS; agc_locked=1 once lock_cnt reaches LOCK_WINDOWS.
  - peak_out <= final peak at every window end, in both MEASURE and SETTLE. peak_acc restarts at 0 for the next window.
  - SETTLE: one full window is counted and its peak is reported on peak_out, but no evaluation is made. This lets the IIR transient decay. Return to MEASURE at its end.
- Latency: gain_out changes on the clock edge that captures the window's last sample. gain_step is high for exactly that one cycle.
- agc_en falling in any state: the next cycle is MANUAL. Any partial window is discarded, and gain_out takes clamp(gain_manual).
- sample_en low: nothing advances. A window spans sample counts, not cycles.
- Widths: win_cnt is WIN_LOG2 bits and wraps naturally. quiet_cnt and lock_cnt are wide enough for their parameters.

Decomposition:
- Package if_agc_pkg holds:
  - GAIN_MAX=5 and the gain code width (3);
  - the state encoding (MANUAL, MEASURE, SETTLE);
  - the clamp function for manual codes.
- One sub-module, if_agc_peak. It computes magnitude with saturation, runs the window counter and peak accumulator, and outputs win_done plus the final peak. The FSM, gain register and hold/lock counters stay in if_agc_ctrl.

Test Plan:
- Reset and manual passthrough: assert RSTb low mid-run → gain_out=0 and peak_out=0 asynchronously. With agc_en=0, drive gain_manual=3 then 7 → gain_out=3, then 5.
- Attack (WIN_LOG2=4): start at gain 4, agc_en=1, feed a constant 100 → after 16 samples gain_out=3 with one gain_step pulse and peak_out=100. The SETTLE window of 16 makes no change. The next window steps to 2.
- Decay with hold: start at gain 2, feed ±10 → gain_out steps to 3 only at the end of the 4th quiet window. It then skips the SETTLE window and needs 4 more quiet windows before stepping to 4. Codes stop at 5 with no further gain_step.
- Lock and saturation: feed 60, then -128 → agc_locked=1 after 2 in-band windows. The -128 window reads peak_out=127, steps gain down and clears agc_locked.
- sample_en gaps and abort: toggle sample_en every other cycle → a window completes after 16 enabled samples, i.e. 32 cycles. Drop agc_en at sample 8 → gain_out equals gain_manual next cycle. Re-enabling starts a fresh 16-sample window.
